// File: rtl/vga_out_stage.sv
// vga_out_stage: VGA timing counters plus registered, blanked TinyVGA Pmod output
module vga_out_stage #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [5:0] rgb_in,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       active,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_cnt,
    output logic [7:0] uo_out
);
    localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [7:0] UO_RST = {~SYNC_POL, 3'b000, ~SYNC_POL, 3'b000};

    logic [9:0] hcount_q, hcount_d, vcount_q, vcount_d;
    logic [7:0] frame_cnt_q, frame_cnt_d, uo_q, uo_d;
    logic       h_wrap, v_wrap, hsync, vsync;
    logic [5:0] rgb;

    always_comb begin
        h_wrap      = hcount_q == H_LAST;
        v_wrap      = vcount_q == V_LAST;
        hcount_d    = ena ? (h_wrap ? 10'd0 : hcount_q + 10'd1) : hcount_q;
        vcount_d    = (ena && h_wrap) ? (v_wrap ? 10'd0 : vcount_q + 10'd1) : vcount_q;
        frame_cnt_d = (ena && h_wrap && v_wrap) ? frame_cnt_q + 8'd1 : frame_cnt_q;
        hsync       = (hcount_q >= HS_BEG && hcount_q < HS_END) ? SYNC_POL : ~SYNC_POL;
        vsync       = (vcount_q >= VS_BEG && vcount_q < VS_END) ? SYNC_POL : ~SYNC_POL;
        rgb         = active ? rgb_in : 6'd0;
        // Pmod order interleaves the low colour bits with hsync and the high bits with vsync
        uo_d        = ena ? {hsync, rgb[0], rgb[2], rgb[4], vsync, rgb[1], rgb[3], rgb[5]} : uo_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hcount_q    <= 10'd0;
            vcount_q    <= 10'd0;
            frame_cnt_q <= 8'd0;
            uo_q        <= UO_RST;
        end else begin
            hcount_q    <= hcount_d;
            vcount_q    <= vcount_d;
            frame_cnt_q <= frame_cnt_d;
            uo_q        <= uo_d;
        end
    end

    assign x           = hcount_q;
    assign y           = vcount_q;
    assign active      = hcount_q < H_ACT && vcount_q < V_ACT;
    assign line_start  = hcount_q == 10'd0;
    assign frame_start = line_start && vcount_q == 10'd0;
    assign frame_cnt   = frame_cnt_q;
    assign uo_out      = uo_q;
endmodule

// File: tb/tb_vga_out_stage.sv
// tb_vga_out_stage: full-size and shrunken-timing instances checked against an arithmetic model
module tb_vga_out_stage;
    logic       clk = 1'b0, rst_n = 1'b0, ena = 1'b1;
    logic [5:0] rgb_in = 6'h3F;
    logic [9:0] xa, ya, xb, yb;
    logic       act_a, ls_a, fs_a, act_b, ls_b, fs_b;
    logic [7:0] fc_a, fc_b, uo_a, uo_b;
    int         checks = 0, failures = 0;
    longint     t = 0;
    logic [7:0] exp_a = 8'h88, exp_b = 8'h88;
    bit         valid = 1'b0;

    always #5 clk = ~clk;

    vga_out_stage dut_a (
        .clk(clk), .rst_n(rst_n), .ena(ena), .rgb_in(rgb_in), .x(xa), .y(ya),
        .active(act_a), .line_start(ls_a), .frame_start(fs_a), .frame_cnt(fc_a), .uo_out(uo_a)
    );

    // Small timing (16x8 frame) so frame_cnt can be taken through its wrap in a short run
    vga_out_stage #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .ena(ena), .rgb_in(rgb_in), .x(xb), .y(yb),
        .active(act_b), .line_start(ls_b), .frame_start(fs_b), .frame_cnt(fc_b), .uo_out(uo_b)
    );

    function automatic logic [7:0] pack(int hc, int vc, logic [5:0] c,
                                        int ha, int hf, int hs, int va, int vf, int vs);
        logic [5:0] m;
        logic       hn, vn;
        m  = (hc < ha && vc < va) ? c : 6'd0;
        hn = !(hc >= ha + hf && hc < ha + hf + hs);
        vn = !(vc >= va + vf && vc < va + vf + vs);
        return {hn, m[0], m[2], m[4], vn, m[1], m[3], m[5]};
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0d", name, act, exp, t);
        end
    endtask

    // t = enabled cycles since reset; everything else follows by division
    always @(posedge clk) begin
        if (!rst_n) begin
            t     <= 0;
            exp_a <= 8'h88;
            exp_b <= 8'h88;
            valid <= 1'b1;
        end else if (ena) begin
            exp_a <= pack(int'(t % 800), int'((t / 800) % 525), rgb_in, 640, 16, 96, 480, 10, 2);
            exp_b <= pack(int'(t % 16), int'((t / 16) % 8), rgb_in, 8, 2, 3, 4, 1, 2);
            t     <= t + 1;
        end
    end

    always @(negedge clk) begin : cmp
        longint ha, va, hb, vb;
        if (valid) begin
            ha = t % 800; va = (t / 800) % 525;
            hb = t % 16;  vb = (t / 16) % 8;
            chk("x_a", xa, ha);
            chk("y_a", ya, va);
            chk("active_a", act_a, (ha < 640 && va < 480) ? 1 : 0);
            chk("line_start_a", ls_a, ha == 0 ? 1 : 0);
            chk("frame_start_a", fs_a, (ha == 0 && va == 0) ? 1 : 0);
            chk("frame_cnt_a", fc_a, (t / 420000) % 256);
            chk("uo_a", uo_a, exp_a);
            chk("x_b", xb, hb);
            chk("y_b", yb, vb);
            chk("active_b", act_b, (hb < 8 && vb < 4) ? 1 : 0);
            chk("line_start_b", ls_b, hb == 0 ? 1 : 0);
            chk("frame_start_b", fs_b, (hb == 0 && vb == 0) ? 1 : 0);
            chk("frame_cnt_b", fc_b, (t / 128) % 256);
            chk("uo_b", uo_b, exp_b);
        end
    end

    task automatic wait_x(input int target);
        for (int i = 0; i < 2000 && xa != 10'(target); i++) @(negedge clk);
        if (xa != 10'(target)) chk("wait_x_timeout", xa, target);
    endtask

    initial begin
        int n;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst_uo", uo_a, 8'h88);
        chk("rst_x", xa, 0);
        chk("rst_y", ya, 0);
        chk("rst_fc", fc_a, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("first_x", xa, 1);
        chk("first_uo", uo_a, 8'hFF);
        chk("first_rgb", uo_a & 8'h77, 8'h77);
        wait_x(640);
        chk("last_visible_rgb", uo_a & 8'h77, 8'h77);
        @(negedge clk);
        chk("first_blank_rgb", uo_a & 8'h77, 8'h00);
        wait_x(656);
        chk("hsync_before", uo_a[7], 1);
        @(negedge clk);
        chk("hsync_start", uo_a[7], 0);
        n = 1;
        for (int i = 0; i < 200 && !uo_a[7]; i++) begin
            @(negedge clk);
            if (!uo_a[7]) n++;
        end
        chk("hsync_width", n, 96);
        chk("hsync_end_x", xa, 753);
        wait_x(300);
        ena = 1'b0;
        repeat (10) @(negedge clk);
        chk("hold_x", xa, 300);
        ena = 1'b1;
        @(negedge clk);
        chk("resume_x", xa, 301);
        for (int i = 0; i < 20000; i++) begin
            rgb_in = 6'($urandom);
            ena    = $urandom_range(0, 15) != 0;
            @(negedge clk);
        end
        ena = 1'b1;
        for (int i = 0; i < 15000; i++) begin
            rgb_in = 6'($urandom);
            @(negedge clk);
        end
        chk("small_frames_wrapped", (t / 128) >= 256 ? 1 : 0, 1);
        wait_x(500);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_x", xa, 0);
        chk("midrst_y", ya, 0);
        chk("midrst_uo", uo_a, 8'h88);
        chk("midrst_fc", fc_a, 0);
        chk("midrst_fc_b", fc_b, 0);
        repeat (50) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/vga_out_stage.md
Name: vga_out_stage

Overview:
- Output stage of the demo top: generates 640x480@60 VGA timing (25.175 MHz pixel clock) and hands the pixel coordinates to the pixel generator.
- Registers the generator's 6-bit colour, blanks it outside the visible area, and packs it with the syncs into TinyVGA Pmod order on uo_out.
- The top-level testbench observes uo_out directly.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch
- SYNC_POL, 0, sync asserted level (0 = active-low)

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  synchronous active-low reset
- ena  in  1  count enable; low freezes all state
- rgb_in  in  6  {R1,R0,G1,G0,B1,B0} from pixel generator, combinational in x/y
- x  out  10  current hcount
- y  out  10  current vcount
- active  out  1  hcount<H_ACTIVE and vcount<V_ACTIVE
- line_start  out  1  high when hcount==0
- frame_start  out  1  high when hcount==0 and vcount==0
- frame_cnt  out  8  completed-frame counter
- uo_out  out  8  {hsync,B0,G0,R0,vsync,B1,G1,R1}, registered

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n, sampled on the clk rising edge. Reset has priority over ena.
- Reset values:
  - hcount=0, vcount=0, frame_cnt=0.
  - uo_out has syncs deasserted and RGB=0. With SYNC_POL=0 this is 8'h88.
- Derived constants:
  - H_TOTAL = sum of the H parameters (800).
  - V_TOTAL = sum of the V parameters (525).
  - All arithmetic is unsigned, 10-bit.
- hcount: increments each ena cycle and wraps H_TOTAL-1 -> 0.
- vcount: increments when hcount wraps; wraps V_TOTAL-1 -> 0.
- frame_cnt: increments when both counters wrap on the same cycle. It wraps 255 -> 0.
- Sync regions, before the output register:
  - hsync is asserted while H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vsync is asserted while V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC (490..491).
- x, y, active, line_start and frame_start are combinational from the counter registers (cycle n).
- uo_out pipeline:
  - uo_out at cycle n+1 carries the sync and blanked RGB computed from cycle-n counters and cycle-n rgb_in.
  - Latency from coordinate to pin is exactly 1 cycle for colour and syncs alike (they stay aligned).
- Blanking: when active=0, the RGB bits of uo_out register to 0 regardless of rgb_in.
- ena=0: counters, frame_cnt and uo_out hold their values. The combinational outputs follow the held counters.
- Reset mid-frame: takes effect on the next edge. The counters go to 0/0 and uo_out goes to its reset value with no partial-line continuation. The cycle after rst_n rises shows hcount=0 pixel data in uo_out.
- Simultaneous h-wrap and v-wrap: vcount goes to 0 and frame_cnt increments on the same edge.

Test Plan:
- Reset: hold rst_n=0 for 5 clocks with rgb_in=6'h3F, ena=1 -> uo_out=8'h88, x=0, y=0, frame_cnt=0. Release -> first clock: x=1, and uo_out shows pixel (0,0) colour 6'h3F packed as 8'h77.
- Hsync timing: after release, uo_out[7] is low exactly when the registered hcount was 656..751 -> 96 consecutive low cycles per line; period 800 cycles.
- Line/frame wrap: run 800*525 cycles -> y steps 0..524 then 0; frame_start pulses once; frame_cnt=1; uo_out[3] is low for exactly 2 lines (registered vcount 490, 491).
- Blanking: rgb_in=6'h3F constant -> uo_out RGB bits are 0 for hcount 640..799 and for lines 480..524; all-ones within the visible area.
- Enable hold: drop ena for 10 cycles at hcount=300 -> x stays 300 and uo_out is unchanged; resumes at 301 when ena returns.
- Mid-frame reset: assert rst_n=0 for 1 cycle at (x=500, y=200) -> next cycle x=0, y=0, uo_out=8'h88; frame_cnt=0.
